// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// The ALU is driven combinationally by the winner; its result is registered and returned on a response channel.
module alu_arbiter #(
  parameter int XLEN         = 32,
  parameter int ALU_OP_WIDTH = 4,
  parameter int NUM_REQ      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*XLEN-1:0]      req_src1,
  input  logic [NUM_REQ*XLEN-1:0]      req_src2,
  input  logic [NUM_REQ*ALU_OP_WIDTH-1:0] req_op,
  output logic [XLEN-1:0]              alu_src1,
  output logic [XLEN-1:0]              alu_src2,
  output logic [ALU_OP_WIDTH-1:0]      alu_op,
  input  logic [XLEN-1:0]              alu_result,
  input  logic                         alu_zero,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [XLEN-1:0]              rsp_result,
  output logic                         rsp_zero
);

  localparam int              LGW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [LGW:0]    NUM_REQ_W = (LGW+1)'(NUM_REQ);
  localparam logic [LGW-1:0]  LAST_RST  = LGW'(NUM_REQ - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e              state_q;
  logic [LGW-1:0]      last_grant_q;
  logic [LGW-1:0]      rsp_owner_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [XLEN-1:0]     rsp_result_q;
  logic                rsp_zero_q;

  logic                can_accept_s;
  logic                win_found_s;
  logic [LGW-1:0]      win_idx_s;
  logic [LGW:0]        scan_sum_s;
  logic [LGW-1:0]      scan_idx_s;
  logic                scan_hit_s;
  logic [NUM_REQ-1:0]  sel_vec_s;
  logic                grant_s;
  logic [XLEN-1:0]     alu_src1_s;
  logic [XLEN-1:0]     alu_src2_s;
  logic [ALU_OP_WIDTH-1:0] alu_op_s;

  // Accept condition: idle, or the held response is being consumed this cycle
  always_comb begin
    can_accept_s = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready[rsp_owner_q]);
  end

  // Round-robin scan starting just after the last grant; the first valid requester wins
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_sum_s  = '0;
    scan_idx_s  = '0;
    scan_hit_s  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_sum_s  = {1'b0, last_grant_q} + (LGW+1)'(k);
      scan_idx_s  = (scan_sum_s >= NUM_REQ_W) ? LGW'(scan_sum_s - NUM_REQ_W) : scan_sum_s[LGW-1:0];
      scan_hit_s  = ~win_found_s & req_valid[scan_idx_s];
      win_idx_s   = scan_hit_s ? scan_idx_s : win_idx_s;
      win_found_s = win_found_s | scan_hit_s;
    end
  end

  // One-hot grant and AND-OR operand mux; zero operands (ADD) when nobody is granted
  always_comb begin
    sel_vec_s  = '0;
    alu_src1_s = '0;
    alu_src2_s = '0;
    alu_op_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_vec_s[i] = can_accept_s & win_found_s & (win_idx_s == LGW'(i));
      alu_src1_s   = alu_src1_s | (req_src1[i*XLEN +: XLEN] & {XLEN{sel_vec_s[i]}});
      alu_src2_s   = alu_src2_s | (req_src2[i*XLEN +: XLEN] & {XLEN{sel_vec_s[i]}});
      alu_op_s     = alu_op_s | (req_op[i*ALU_OP_WIDTH +: ALU_OP_WIDTH] & {ALU_OP_WIDTH{sel_vec_s[i]}});
    end
    grant_s = |sel_vec_s;
  end

  // Grant FSM and response registers; a grant always (re)loads the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_RST;
      rsp_owner_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else if (grant_s) begin
      state_q      <= ST_RESP;
      last_grant_q <= win_idx_s;
      rsp_owner_q  <= win_idx_s;
      rsp_valid_q  <= sel_vec_s;
      rsp_result_q <= alu_result;
      rsp_zero_q   <= alu_zero;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_RESP: begin
          if (rsp_ready[rsp_owner_q]) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= '0;
          end else begin
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= '0;
        end
      endcase
    end
  end

  // Handshake is suppressed while reset is asserted
  assign req_ready  = sel_vec_s & {NUM_REQ{rst_n}};
  assign alu_src1   = alu_src1_s;
  assign alu_src2   = alu_src2_s;
  assign alu_op     = alu_op_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester instance plus a 3-requester instance,
// each wired to a small behavioural ALU.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_SRA = 4'b1101;

  logic clk;
  logic rst_n;

  logic [1:0]  a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [63:0] a_src1, a_src2;
  logic [7:0]  a_op;
  logic [31:0] a_alu_src1, a_alu_src2, a_alu_result, a_rsp_result;
  logic [3:0]  a_alu_op;
  logic        a_alu_zero, a_rsp_zero;

  logic [2:0]  b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [95:0] b_src1, b_src2;
  logic [11:0] b_op;
  logic [31:0] b_alu_src1, b_alu_src2, b_alu_result, b_rsp_result;
  logic [3:0]  b_alu_op;
  logic        b_alu_zero, b_rsp_zero;

  int n_checks = 0;
  int n_fail   = 0;

  int          exp_res [4] = '{32'd23, 32'd42, 32'd24, 32'd43};
  logic [1:0]  exp_rdy;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      OP_ADD:  alu_model = a + b;
      OP_SUB:  alu_model = a - b;
      OP_SLL:  alu_model = a << b[4:0];
      OP_SRA:  alu_model = $unsigned($signed(a) >>> b[4:0]);
      default: alu_model = 32'd0;
    endcase
  endfunction

  assign a_alu_result = alu_model(a_alu_src1, a_alu_src2, a_alu_op);
  assign a_alu_zero   = (a_alu_result == 32'd0);
  assign b_alu_result = alu_model(b_alu_src1, b_alu_src2, b_alu_op);
  assign b_alu_zero   = (b_alu_result == 32'd0);

  alu_arbiter #(.XLEN(32), .ALU_OP_WIDTH(4), .NUM_REQ(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_src1(a_src1), .req_src2(a_src2), .req_op(a_op),
    .alu_src1(a_alu_src1), .alu_src2(a_alu_src2), .alu_op(a_alu_op),
    .alu_result(a_alu_result), .alu_zero(a_alu_zero),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_result(a_rsp_result), .rsp_zero(a_rsp_zero)
  );

  alu_arbiter #(.XLEN(32), .ALU_OP_WIDTH(4), .NUM_REQ(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_src1(b_src1), .req_src2(b_src2), .req_op(b_op),
    .alu_src1(b_alu_src1), .alu_src2(b_alu_src2), .alu_op(b_alu_op),
    .alu_result(b_alu_result), .alu_zero(b_alu_zero),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_result(b_rsp_result), .rsp_zero(b_rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int r, input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] op);
    a_src1[r*32 +: 32] = s1;
    a_src2[r*32 +: 32] = s2;
    a_op[r*4 +: 4]     = op;
  endtask

  task automatic set_b(input int r, input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] op);
    b_src1[r*32 +: 32] = s1;
    b_src2[r*32 +: 32] = s2;
    b_op[r*4 +: 4]     = op;
  endtask

  initial begin
    rst_n = 1'b0;
    a_req_valid = 2'b11; a_rsp_ready = 2'b11; a_src1 = '0; a_src2 = '0; a_op = '0;
    b_req_valid = 3'b000; b_rsp_ready = 3'b111; b_src1 = '0; b_src2 = '0; b_op = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 64'(a_req_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    check_eq("rst_rsp_result", 64'(a_rsp_result), 64'd0);
    check_eq("rst_rsp_zero", 64'(a_rsp_zero), 64'd0);
    check_eq("rst_b_rsp_valid", 64'(b_rsp_valid), 64'd0);
    rst_n = 1'b1;
    a_req_valid = 2'b00;
    #1;
    check_eq("idle_alu_src1", 64'(a_alu_src1), 64'd0);
    check_eq("idle_alu_op", 64'(a_alu_op), 64'd0);
    check_eq("idle_req_ready", 64'(a_req_ready), 64'd0);

    // Single requester 0: 5 + 7
    @(negedge clk);
    set_a(0, 32'd5, 32'd7, OP_ADD);
    a_req_valid = 2'b01;
    #1;
    check_eq("t1_req_ready", 64'(a_req_ready), 64'h1);
    check_eq("t1_alu_src1", 64'(a_alu_src1), 64'd5);
    @(posedge clk); #1;
    check_eq("t1_rsp_valid", 64'(a_rsp_valid), 64'h1);
    check_eq("t1_rsp_result", 64'(a_rsp_result), 64'd12);
    check_eq("t1_rsp_zero", 64'(a_rsp_zero), 64'd0);

    // Single requester 1: 9 - 9
    @(negedge clk);
    set_a(1, 32'd9, 32'd9, OP_SUB);
    a_req_valid = 2'b10;
    #1;
    check_eq("t2_req_ready", 64'(a_req_ready), 64'h2);
    @(posedge clk); #1;
    check_eq("t2_rsp_valid", 64'(a_rsp_valid), 64'h2);
    check_eq("t2_rsp_result", 64'(a_rsp_result), 64'd0);
    check_eq("t2_rsp_zero", 64'(a_rsp_zero), 64'd1);

    // Both valid, responses consumed at once: strict alternation, no bubbles
    @(negedge clk);
    set_a(0, 32'd20, 32'd3, OP_ADD);
    set_a(1, 32'd50, 32'd8, OP_SUB);
    a_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if ((k % 2) == 1) set_a(0, a_src1[31:0] + 32'd1, 32'd3, OP_ADD);
        else              set_a(1, a_src1[63:32] + 32'd1, 32'd8, OP_SUB);
      end
      exp_rdy = ((k % 2) == 1) ? 2'b10 : 2'b01;
      #1;
      check_eq($sformatf("t3_req_ready_%0d", k), 64'(a_req_ready), 64'(exp_rdy));
      @(posedge clk); #1;
      check_eq($sformatf("t3_rsp_valid_%0d", k), 64'(a_rsp_valid), 64'(exp_rdy));
      check_eq($sformatf("t3_rsp_result_%0d", k), 64'(a_rsp_result), 64'(exp_res[k]));
    end

    // Owner 1 stalls for 3 cycles; non-owner ready bit must be ignored
    @(negedge clk);
    set_a(1, 32'd52, 32'd8, OP_SUB);
    set_a(0, 32'd22, 32'd3, OP_ADD);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clk);
      a_rsp_ready = 2'b01;
      #1;
      check_eq($sformatf("t4_stall_ready_%0d", s), 64'(a_req_ready), 64'd0);
      check_eq($sformatf("t4_stall_alu_src1_%0d", s), 64'(a_alu_src1), 64'd0);
      @(posedge clk); #1;
      check_eq($sformatf("t4_stall_valid_%0d", s), 64'(a_rsp_valid), 64'h2);
      check_eq($sformatf("t4_stall_result_%0d", s), 64'(a_rsp_result), 64'd43);
    end
    @(negedge clk);
    a_rsp_ready = 2'b11;
    #1;
    check_eq("t4_accept_ready", 64'(a_req_ready), 64'h1);
    @(posedge clk); #1;
    check_eq("t4_accept_valid", 64'(a_rsp_valid), 64'h1);
    check_eq("t4_accept_result", 64'(a_rsp_result), 64'd25);

    // Reset pulse while holding a response
    @(negedge clk);
    a_rsp_ready = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", 64'(a_rsp_valid), 64'd0);
    check_eq("t5_rst_ready", 64'(a_req_ready), 64'd0);
    check_eq("t5_rst_result", 64'(a_rsp_result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_a(0, 32'd30, 32'd4, OP_ADD);
    set_a(1, 32'd60, 32'd6, OP_SUB);
    a_req_valid = 2'b11;
    a_rsp_ready = 2'b11;
    #1;
    check_eq("t5_first_ready", 64'(a_req_ready), 64'h1);
    @(posedge clk); #1;
    check_eq("t5_first_valid", 64'(a_rsp_valid), 64'h1);
    check_eq("t5_first_result", 64'(a_rsp_result), 64'd34);
    @(negedge clk);
    a_req_valid = 2'b00;
    @(posedge clk); #1;
    check_eq("t5_drain_valid", 64'(a_rsp_valid), 64'd0);

    // Three requesters, last_grant=2 after reset, requesters 1 and 2 valid
    @(negedge clk);
    set_b(1, 32'd1, 32'd4, OP_SLL);
    set_b(2, 32'h8000_0000, 32'd4, OP_SRA);
    b_req_valid = 3'b110;
    #1;
    check_eq("t6_g0_ready", 64'(b_req_ready), 64'h2);
    check_eq("t6_g0_op", 64'(b_alu_op), 64'(OP_SLL));
    @(posedge clk); #1;
    check_eq("t6_g0_valid", 64'(b_rsp_valid), 64'h2);
    check_eq("t6_g0_result", 64'(b_rsp_result), 64'd16);
    @(negedge clk);
    set_b(1, 32'd3, 32'd2, OP_SLL);
    #1;
    check_eq("t6_g1_ready", 64'(b_req_ready), 64'h4);
    check_eq("t6_g1_op", 64'(b_alu_op), 64'(OP_SRA));
    @(posedge clk); #1;
    check_eq("t6_g1_valid", 64'(b_rsp_valid), 64'h4);
    check_eq("t6_g1_result", 64'(b_rsp_result), 64'hF800_0000);
    check_eq("t6_g1_zero", 64'(b_rsp_zero), 64'd0);
    @(negedge clk);
    #1;
    check_eq("t6_g2_ready", 64'(b_req_ready), 64'h2);
    check_eq("t6_g2_op", 64'(b_alu_op), 64'(OP_SLL));
    @(posedge clk); #1;
    check_eq("t6_g2_valid", 64'(b_rsp_valid), 64'h2);
    check_eq("t6_g2_result", 64'(b_rsp_result), 64'd12);
    @(negedge clk);
    b_req_valid = 3'b000;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
